// File: rtl/bandai2003_so_decoder.sv
// Frames the mapper's synchronous SO unlock stream: idle-high guard, start 0,
// DATA_W data bits LSB first, end bit 0. Reports data, match, framing errors.
module bandai2003_so_decoder #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] EXPECT   = 16'h28A0,
  parameter int                IDLE_MIN = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              SI,
  input  logic              CLR,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  output logic              MATCH,
  output logic              FERR,
  output logic              UNLK,
  output logic [3:0]        FCNT
);

  localparam int         BW   = $clog2(DATA_W + 1);
  localparam logic [3:0] IMIN = IDLE_MIN[3:0];

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_END} st_t;

  st_t               st;
  logic [3:0]        icnt;
  logic [BW-1:0]     bcnt;
  logic [DATA_W-1:0] sr;
  logic              hit;

  assign hit = (sr == EXPECT);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st    <= S_IDLE;
      icnt  <= '0;
      bcnt  <= '0;
      sr    <= '0;
      DATA  <= '0;
      VALID <= 1'b0;
      MATCH <= 1'b0;
      FERR  <= 1'b0;
      UNLK  <= 1'b0;
      FCNT  <= '0;
    end else begin
      VALID <= 1'b0;
      MATCH <= 1'b0;
      FERR  <= 1'b0;
      if (CLR) begin
        UNLK <= 1'b0;
        FCNT <= '0;
      end
      case (st)
        S_IDLE: begin
          if (!SI)
            icnt <= '0;
          else if (icnt + 4'd1 >= IMIN) begin
            icnt <= IMIN;
            st   <= S_ARMED;
          end else
            icnt <= icnt + 4'd1;
        end
        S_ARMED: begin
          if (!SI) begin
            st   <= S_SHIFT;
            bcnt <= '0;
          end
        end
        S_SHIFT: begin
          sr   <= {SI, sr[DATA_W-1:1]};
          bcnt <= bcnt + BW'(1);
          if (bcnt == BW'(DATA_W - 1))
            st <= S_END;
        end
        default: begin
          st   <= S_IDLE;
          icnt <= '0;
          // A good frame completing alongside CLR overrides the clear
          if (!SI) begin
            DATA  <= sr;
            VALID <= 1'b1;
            MATCH <= hit;
            if (CLR)
              FCNT <= 4'd1;
            else if (FCNT != 4'hF)
              FCNT <= FCNT + 4'd1;
            if (hit)
              UNLK <= 1'b1;
          end else begin
            FERR <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bandai2003_so_decoder.md
Name: bandai2003_so_decoder

Overview:
- Console-side consumer of the mapper's synchronous serial output (SO).
- Samples the line once per CLK, frames the unlock bit-stream and extracts its 16 data bits.
- Flags whether the frame carries the SYSTEM_CTRL1 unlock word, and tracks unlock status and frame count.
- Used in the cartridge emulation FPGA and as the bench-side checker for the mapper.

Parameters:
- DATA_W, 16, data bits per frame.
- EXPECT, 16'h28A0, unlock word that sets MATCH and UNLK.
- IDLE_MIN, 2, consecutive high samples required before a start bit is accepted (range 1..15).

Ports:
- CLK  in  1  bit clock; same clock that shifts the mapper's SO.
- RSTn  in  1  asynchronous, active-low reset.
- SI  in  1  serial line from mapper SO; idle high; pulled high on board when the mapper tri-states it.
- CLR  in  1  synchronous clear of UNLK and FCNT.
- DATA  out  DATA_W  last completed frame's data bits.
- VALID  out  1  one-cycle pulse on frame completion.
- MATCH  out  1  qualifies VALID: end bit correct and DATA == EXPECT.
- FERR  out  1  one-cycle pulse on framing error.
- UNLK  out  1  sticky: a matching frame has been received.
- FCNT  out  4  count of correctly framed frames; saturating.

Behaviour:
- Line format:
  - Idle is 1.
  - Start bit is 0.
  - Then DATA_W data bits, LSB first.
  - Then one end bit that must be 0.
  - Line then returns to 1.
  - One bit per CLK, sampled on the rising edge. No oversampling and no synchronizer; SI is synchronous to CLK.
- Reset (RSTn low, asynchronous):
  - DATA=0, VALID=0, MATCH=0, FERR=0, UNLK=0, FCNT=0.
  - State=IDLE, idle counter=0, bit counter=0.
- State IDLE:
  - Each SI=1 sample increments the idle counter, saturating at IDLE_MIN.
  - An SI=0 sample clears the counter.
  - Go to ARMED when the counter reaches IDLE_MIN.
- State ARMED:
  - SI=1: stay.
  - SI=0: that sample is the start bit; go to SHIFT with bit counter=0.
- State SHIFT:
  - Each edge shifts SI into the MSB of the shift register (right shift), so the first data bit ends in bit 0.
  - The bit counter increments each edge.
  - After DATA_W samples, go to END.
  - Data zeros never restart framing.
- State END:
  - Sample the end bit and go to IDLE with the idle counter=0.
  - End bit 0 (good frame):
    - Next cycle: DATA=shift register, VALID=1, MATCH=(shift register==EXPECT).
    - FCNT increments, saturating at 15.
    - UNLK is set if MATCH.
  - End bit 1 (bad frame):
    - Next cycle: FERR=1, VALID=0, MATCH=0.
    - DATA, UNLK and FCNT are unchanged.
- Timing:
  - If the start bit is sampled at edge n, data bits are at edges n+1..n+DATA_W and the end bit at edge n+DATA_W+1.
  - VALID/FERR are high for exactly the cycle after edge n+DATA_W+1.
- Registering and pulse widths:
  - MATCH is registered together with VALID and is low whenever VALID is low.
  - VALID and FERR are never high together and are single-cycle pulses.
- Back-to-back frames: the next start is accepted only after IDLE_MIN further high samples. A 0 earlier than that is ignored.
- CLR:
  - Clears UNLK and FCNT on the next edge.
  - If a good frame completes on the same edge, the frame wins over the clear: FCNT=1, and UNLK=MATCH.
  - CLR does not affect framing, DATA or the pulse outputs.
- Reset mid-frame: all state is lost immediately and no pulse is produced. After release, IDLE_MIN highs are needed before a new start.
- Widths:
  - Bit counter is ceil(log2(DATA_W+1)) bits.
  - The comparison is across the full DATA_W bits.

Test Plan:
- Mapper unlock stream:
  - Stimulus: reset, 8 highs, then 0, bits of 16'h28A0 LSB first, 0, then highs.
  - Response: VALID pulse 18 cycles after the start-bit edge; DATA=16'h28A0, MATCH=1, UNLK=1, FCNT=1, FERR never high.
- Wrong word:
  - Stimulus: same frame carrying 16'h1234 after reset.
  - Response: VALID=1, MATCH=0, DATA=16'h1234, UNLK=0, FCNT=1.
- Framing error:
  - Stimulus: frame carrying 16'h28A0 with end bit 1.
  - Response: FERR pulse; VALID=0; DATA, UNLK and FCNT keep their prior values.
- Idle guard (IDLE_MIN=2):
  - Stimulus A: SI=0 on the first edge after reset.
  - Response A: ignored.
  - Stimulus B: a start arriving only 1 high sample after a completed frame.
  - Response B: ignored.
  - Stimulus C: start after 2 highs.
  - Response C: accepted.
- Reset mid-frame:
  - Stimulus: pull RSTn low during data bit 7.
  - Response: all outputs 0 asynchronously; no VALID/FERR; a following full frame decodes correctly.
- Saturation and CLR:
  - Stimulus: 17 good frames.
  - Response: FCNT=15 (stays at 15).
  - Stimulus: CLR alone.
  - Response: FCNT=0, UNLK=0.
  - Stimulus: CLR asserted on the same edge a matching frame completes.
  - Response: FCNT=1, UNLK=1.
